// File: rtl/uart_tx_word.sv
// uart_tx_word: multi-byte UART transmitter, LSB byte first, runtime divisor/parity/stop bits
module uart_tx_word #(
  parameter int NUM_BYTES = 4,
  parameter int DIV_W     = 12,
  parameter int CNT_W     = 3
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic                   i_Tx_DV,
  output logic                   o_Tx_Ready,
  input  logic [8*NUM_BYTES-1:0] i_Tx_Word,
  input  logic [CNT_W-1:0]       i_Num_Bytes,
  input  logic [DIV_W-1:0]       i_Clks_Per_Bit,
  input  logic                   i_Parity_En,
  input  logic                   i_Parity_Odd,
  input  logic                   i_Two_Stop,
  output logic                   o_Tx_Serial,
  output logic                   o_Tx_Active,
  output logic                   o_Byte_Done,
  output logic                   o_Tx_Done
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] NEXT   = 3'd5;
  localparam logic [CNT_W-1:0] NB      = CNT_W'(NUM_BYTES);
  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);

  logic [2:0]             state;
  logic [DIV_W-1:0]       cnt;
  logic [DIV_W-1:0]       div;
  logic [2:0]             bit_idx;
  logic                   stop_sec;
  logic [CNT_W-1:0]       byte_idx;
  logic [CNT_W-1:0]       num;
  logic [8*NUM_BYTES-1:0] word;
  logic                   par_en;
  logic                   par_odd;
  logic                   two_stop;
  logic                   accept;
  logic                   bit_end;
  logic                   last_byte;
  logic                   stop_end;
  logic [7:0]             cur;
  logic [CNT_W-1:0]       num_in;
  logic [DIV_W-1:0]       div_in;

  // The byte on the wire is always the low byte of the latched word, which shifts down between frames.
  assign cur       = word[7:0];
  assign accept    = i_Tx_DV & o_Tx_Ready;
  assign bit_end   = cnt == div - DIV_W'(1);
  assign last_byte = byte_idx == num - CNT_W'(1);
  assign stop_end  = state == STOP && bit_end && (!two_stop || stop_sec);
  assign num_in    = (i_Num_Bytes == '0 || i_Num_Bytes > NB) ? NB : i_Num_Bytes;
  assign div_in    = i_Clks_Per_Bit < MIN_DIV ? MIN_DIV : i_Clks_Per_Bit;

  assign o_Tx_Serial = state == START  ? 1'b0 :
                       state == DATA   ? cur[bit_idx] :
                       state == PARITY ? ^cur ^ par_odd : 1'b1;
  assign o_Tx_Active = state != IDLE && state != NEXT;
  assign o_Byte_Done = stop_end;
  assign o_Tx_Done   = stop_end && last_byte;

  // Frame sequencer: latch a word on accept, walk start/data/parity/stop per byte, chain bytes with no gap.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      div        <= '0;
      bit_idx    <= '0;
      stop_sec   <= 1'b0;
      byte_idx   <= '0;
      num        <= '0;
      word       <= '0;
      par_en     <= 1'b0;
      par_odd    <= 1'b0;
      two_stop   <= 1'b0;
      o_Tx_Ready <= 1'b1;
    end else if (accept) begin
      state      <= START;
      cnt        <= '0;
      div        <= div_in;
      bit_idx    <= '0;
      stop_sec   <= 1'b0;
      byte_idx   <= '0;
      num        <= num_in;
      word       <= i_Tx_Word;
      par_en     <= i_Parity_En;
      par_odd    <= i_Parity_Odd;
      two_stop   <= i_Two_Stop;
      o_Tx_Ready <= 1'b0;
    end else begin
      cnt <= (state == IDLE || state == NEXT || bit_end) ? '0 : cnt + DIV_W'(1);
      case (state)
        START:   if (bit_end) state <= DATA;
        DATA:    if (bit_end) begin
                   bit_idx <= bit_idx + 3'd1;
                   if (bit_idx == 3'd7) state <= par_en ? PARITY : STOP;
                 end
        PARITY:  if (bit_end) state <= STOP;
        STOP:    if (bit_end) begin
                   if (two_stop && !stop_sec) stop_sec <= 1'b1;
                   else if (last_byte) begin
                     stop_sec   <= 1'b0;
                     state      <= NEXT;
                     o_Tx_Ready <= 1'b1;
                   end else begin
                     stop_sec <= 1'b0;
                     byte_idx <= byte_idx + CNT_W'(1);
                     word     <= word >> 8;
                     state    <= START;
                   end
                 end
        default: ;
      endcase
    end
  end
endmodule
